pkt_enq_feeder: RTL and testbench

//  Ingress stage directly upstream of pkt_sche_v0_1. Accepts packets on a valid/ready stream and

---
 rtl/heap_ops.sv | 23 ++
 rtl/pkt_feed_fifo.sv | 55 +++++
 rtl/pkt_enq_feeder.sv | 130 +++++++++++++
 tb/tb_pkt_enq_feeder.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/heap_ops.sv
// Shared types and constants for the scheduler ingress path.
package heap_ops;

    // Width of the head-of-line age counter.
    localparam int AGE_W = 8;

    // Default field widths for a packet entry.
    localparam int FEED_PWIDTH = 16;
    localparam int FEED_DWIDTH = 32;

    // One buffered packet: scheduler info word plus data word.
    typedef struct packed {
        logic [FEED_PWIDTH-1:0] info;
        logic [FEED_DWIDTH-1:0] data;
    } feed_entry_t;

    // Output register occupancy.
    typedef enum logic {
        OREG_EMPTY  = 1'b0,
        OREG_LOADED = 1'b1
    } oreg_state_t;

endpackage

// File: rtl/pkt_feed_fifo.sv
// Synchronous FIFO with extra-MSB pointers: full/empty decided by the MSB compare.
// Read data is the current head, visible combinationally from the storage array.
module pkt_feed_fifo #(
    parameter int W     = 48,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [W-1:0]               wdata,
    input  logic                       pop,
    output logic [W-1:0]               rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign count = wr_ptr - rd_ptr;
    assign rdata = mem[rd_ptr[AW-1:0]];

    // Storage write; contents need no reset because pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push && !full && !flush) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    // Pointer update; flush empties the FIFO and wins over push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pkt_enq_feeder.sv
// Ingress stage in front of the packet scheduler: buffers packets in a FIFO and presents
// them one at a time as enqueue operations, flagging urgency on low rank or HOL ageing.
//
// Handshakes: a beat moves on an edge where valid && ready are both high. The upstream side
// offers s_valid and the feeder answers s_ready (= FIFO not full, from registered pointers);
// the feeder offers sch_valid and holds sch_pkt_info/sch_data/sch_ugr_en stable until
// sch_ready is seen high at an edge.
module pkt_enq_feeder
    import heap_ops::*;
#(
    parameter int DWIDTH     = 32,
    parameter int PWIDTH     = 16,
    parameter int RANK_LSB   = 0,
    parameter int RANK_W     = 8,
    parameter int FDEPTH     = 8,
    parameter int UGR_THRESH = 4,
    parameter int AGE_MAX    = 15
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [PWIDTH-1:0]          s_pkt_info,
    input  logic [DWIDTH-1:0]          s_data,
    input  logic                       sch_ready,
    output logic                       sch_valid,
    output logic                       sch_enque_en,
    output logic                       sch_ugr_en,
    output logic [PWIDTH-1:0]          sch_pkt_info,
    output logic [DWIDTH-1:0]          sch_data,
    output logic [$clog2(FDEPTH):0]    occupancy,
    output logic [31:0]                enq_cnt,
    output logic [31:0]                ugr_cnt
);

    localparam int EW = PWIDTH + DWIDTH;
    localparam logic [RANK_W:0]  UGR_LIM = UGR_THRESH[RANK_W:0];
    localparam logic [AGE_W-1:0] AGE_LIM = AGE_MAX[AGE_W-1:0];

    oreg_state_t        oreg_state;
    logic [AGE_W-1:0]   age;
    logic               ugr;

    logic               fifo_full;
    logic               fifo_empty;
    logic [EW-1:0]      fifo_rdata;
    logic               push;
    logic               pop;
    logic               transfer;
    logic [PWIDTH-1:0]  head_info;
    logic [DWIDTH-1:0]  head_data;
    logic [RANK_W-1:0]  head_rank;

    assign s_ready   = !fifo_full;
    assign push      = s_valid && s_ready && !flush;
    assign transfer  = (oreg_state == OREG_LOADED) && sch_ready;
    // Refill the output register when it is empty or is being drained this edge.
    assign pop       = !flush && !fifo_empty && ((oreg_state == OREG_EMPTY) || transfer);

    assign head_info = fifo_rdata[EW-1:DWIDTH];
    assign head_data = fifo_rdata[DWIDTH-1:0];
    assign head_rank = head_info[RANK_LSB +: RANK_W];

    assign sch_valid    = (oreg_state == OREG_LOADED);
    assign sch_enque_en = sch_valid;
    assign sch_ugr_en   = ugr && sch_valid;

    pkt_feed_fifo #(
        .W     (EW),
        .DEPTH (FDEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (push),
        .wdata ({s_pkt_info, s_data}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (occupancy)
    );

    // Output register FSM with ageing, urgency and delivery counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oreg_state   <= OREG_EMPTY;
            age          <= '0;
            ugr          <= 1'b0;
            sch_pkt_info <= '0;
            sch_data     <= '0;
            enq_cnt      <= '0;
            ugr_cnt      <= '0;
        end else if (flush) begin
            oreg_state   <= OREG_EMPTY;
            age          <= '0;
            ugr          <= 1'b0;
            sch_pkt_info <= '0;
            sch_data     <= '0;
        end else begin
            if (transfer) begin
                enq_cnt <= enq_cnt + 32'd1;
                if (ugr) begin
                    ugr_cnt <= ugr_cnt + 32'd1;
                end
            end
            if (pop) begin
                oreg_state   <= OREG_LOADED;
                sch_pkt_info <= head_info;
                sch_data     <= head_data;
                age          <= '0;
                ugr          <= ({1'b0, head_rank} < UGR_LIM);
            end else if (transfer) begin
                oreg_state <= OREG_EMPTY;
                age        <= '0;
                ugr        <= 1'b0;
            end else if (oreg_state == OREG_LOADED) begin
                // Stalled by the scheduler: age saturates at the limit and forces urgency.
                if (age != AGE_LIM) begin
                    age <= age + 1'b1;
                end
                if ((age + 1'b1 == AGE_LIM) || (age == AGE_LIM)) begin
                    ugr <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pkt_enq_feeder.sv
// Directed bench for pkt_enq_feeder with a scoreboard of expected deliveries.
module tb_pkt_enq_feeder;
    import heap_ops::*;

    localparam int P  = 16;
    localparam int D  = 32;
    localparam int EW = 2 + P + D;   // {check_ugr, exp_ugr, info, data}

    logic           clk;
    logic           rst_n;
    logic           flush;
    logic           s_valid;
    logic           s_ready;
    logic [P-1:0]   s_pkt_info;
    logic [D-1:0]   s_data;
    logic           sch_ready;
    logic           sch_valid;
    logic           sch_enque_en;
    logic           sch_ugr_en;
    logic [P-1:0]   sch_pkt_info;
    logic [D-1:0]   sch_data;
    logic [3:0]     occupancy;
    logic [31:0]    enq_cnt;
    logic [31:0]    ugr_cnt;

    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_q[$];

    pkt_enq_feeder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_pkt_info   (s_pkt_info),
        .s_data       (s_data),
        .sch_ready    (sch_ready),
        .sch_valid    (sch_valid),
        .sch_enque_en (sch_enque_en),
        .sch_ugr_en   (sch_ugr_en),
        .sch_pkt_info (sch_pkt_info),
        .sch_data     (sch_data),
        .occupancy    (occupancy),
        .enq_cnt      (enq_cnt),
        .ugr_cnt      (ugr_cnt)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [P-1:0] mk_info(input logic [7:0] tag, input logic [7:0] rank);
        return {tag, rank};
    endfunction

    // Offer one packet, wait (bounded) for acceptance, and record the expected delivery.
    task automatic send(input logic [P-1:0] info, input logic [D-1:0] data,
                        input bit chk, input bit ugr);
        feed_entry_t e;
        int n = 0;
        e.info = info;
        e.data = data;
        s_valid    = 1'b1;
        s_pkt_info = info;
        s_data     = data;
        while (!s_ready && n < 200) begin
            tick();
            n++;
        end
        check("send_ready", s_ready, 1);
        if (s_ready) exp_q.push_back({chk, ugr, e});
        tick();
        s_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    // Scoreboard: each transfer (valid && ready at the coming edge) pops one expectation.
    always @(negedge clk) begin
        if (rst_n && sch_valid && sch_ready) begin
            logic [EW-1:0] e;
            check("sb_nonempty", exp_q.size() != 0, 1);
            check("enque_en", sch_enque_en, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb_info", sch_pkt_info, e[P+D-1:D]);
                check("sb_data", sch_data, e[D-1:0]);
                if (e[EW-1]) check("sb_ugr", sch_ugr_en, e[EW-2]);
            end
        end
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; s_valid = 1'b0; sch_ready = 1'b0;
        s_pkt_info = '0; s_data = '0;
        #12;
        check("rst_s_ready", s_ready, 1);
        check("rst_sch_valid", sch_valid, 0);
        check("rst_occupancy", occupancy, 0);
        check("rst_enq_cnt", enq_cnt, 0);
        rst_n = 1'b1;
        tick();

        // Pass-through: ranks 10, 2, 9 with the scheduler always ready.
        sch_ready = 1'b1;
        send(mk_info(8'h01, 8'd10), 32'd100, 1, 0);
        check("lat_not_yet", sch_valid, 0);
        send(mk_info(8'h02, 8'd2), 32'd101, 1, 1);
        check("lat_valid", sch_valid, 1);
        check("lat_info", sch_pkt_info, mk_info(8'h01, 8'd10));
        send(mk_info(8'h03, 8'd9), 32'd102, 1, 0);
        drain();
        check("pt_enq_cnt", enq_cnt, 3);
        check("pt_ugr_cnt", ugr_cnt, 1);

        // Full FIFO under backpressure; first packet ages into urgency while stalled.
        sch_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            send(mk_info(8'h10 + 8'(i), 8'd40 + 8'(i)), 32'd300 + 32'(i), 1, i == 0);
        end
        s_valid = 1'b1;
        s_pkt_info = mk_info(8'h1f, 8'd99);
        s_data = 32'd399;
        repeat (20) tick();
        check("full_s_ready", s_ready, 0);
        check("full_occupancy", occupancy, 8);
        check("full_sch_valid", sch_valid, 1);
        s_valid = 1'b0;
        sch_ready = 1'b1;
        drain();
        check("full_occ_after", occupancy, 0);
        check("full_enq_cnt", enq_cnt, 12);
        check("full_ugr_cnt", ugr_cnt, 2);

        // Ageing: rank 20 stalled 15 cycles becomes urgent; next packet starts fresh.
        sch_ready = 1'b0;
        send(mk_info(8'hA0, 8'd20), 32'd700, 1, 1);
        s_valid = 1'b1;
        s_pkt_info = mk_info(8'hB0, 8'd30);
        s_data = 32'd701;
        exp_q.push_back({1'b1, 1'b0, mk_info(8'hB0, 8'd30), 32'd701});
        tick();
        s_valid = 1'b0;
        check("age_loaded", sch_valid, 1);
        check("age_ugr_0", sch_ugr_en, 0);
        for (int i = 1; i <= 14; i++) begin
            tick();
            check("age_ugr_low", sch_ugr_en, 0);
        end
        tick();
        check("age_ugr_rise", sch_ugr_en, 1);
        repeat (3) begin
            tick();
            check("age_ugr_hold", sch_ugr_en, 1);
            check("age_info_hold", sch_pkt_info, mk_info(8'hA0, 8'd20));
        end
        sch_ready = 1'b1;
        tick();
        check("age_next_info", sch_pkt_info, mk_info(8'hB0, 8'd30));
        check("age_next_ugr", sch_ugr_en, 0);
        drain();
        check("age_enq_cnt", enq_cnt, 14);
        check("age_ugr_cnt", ugr_cnt, 3);

        // Simultaneous push and pop at occupancy 4.
        sch_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send(mk_info(8'h50 + 8'(i), 8'd60 + 8'(i)), 32'd500 + 32'(i), 1, 0);
        end
        check("pp_occ_start", occupancy, 4);
        sch_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            s_valid = 1'b1;
            s_pkt_info = mk_info(8'h60 + 8'(i), 8'd80 + 8'(i));
            s_data = 32'd600 + 32'(i);
            exp_q.push_back({1'b1, 1'b0, s_pkt_info, s_data});
            tick();
            check("pp_occ", occupancy, 4);
        end
        s_valid = 1'b0;
        drain();
        check("pp_enq_cnt", enq_cnt, 39);
        check("pp_ugr_cnt", ugr_cnt, 3);

        // Flush with occupancy 5 and the output register loaded.
        sch_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            send(mk_info(8'h70 + 8'(i), 8'd70), 32'd800 + 32'(i), 0, 0);
        end
        check("fl_occ_before", occupancy, 5);
        check("fl_valid_before", sch_valid, 1);
        flush = 1'b1;
        s_valid = 1'b1;
        s_pkt_info = mk_info(8'h7f, 8'd1);
        s_data = 32'd899;
        tick();
        flush = 1'b0;
        s_valid = 1'b0;
        exp_q.delete();
        check("fl_valid", sch_valid, 0);
        check("fl_occ", occupancy, 0);
        sch_ready = 1'b1;
        repeat (5) tick();
        check("fl_no_deliver", sch_valid, 0);
        check("fl_enq_cnt", enq_cnt, 39);
        check("fl_ugr_cnt", ugr_cnt, 3);

        // Asynchronous reset mid-stream.
        sch_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(mk_info(8'h90 + 8'(i), 8'd1), 32'd900 + 32'(i), 0, 0);
        end
        s_valid = 1'b1;
        #3;
        rst_n = 1'b0;
        #1;
        check("ar_sch_valid", sch_valid, 0);
        check("ar_enque_en", sch_enque_en, 0);
        check("ar_ugr_en", sch_ugr_en, 0);
        check("ar_info", sch_pkt_info, 0);
        check("ar_data", sch_data, 0);
        check("ar_s_ready", s_ready, 1);
        check("ar_occupancy", occupancy, 0);
        check("ar_enq_cnt", enq_cnt, 0);
        check("ar_ugr_cnt", ugr_cnt, 0);
        s_valid = 1'b0;
        exp_q.delete();
        #2;
        rst_n = 1'b1;
        tick();
        sch_ready = 1'b1;
        send(mk_info(8'hC0, 8'd3), 32'd1000, 1, 1);
        drain();
        check("ar_post_enq", enq_cnt, 1);
        check("ar_post_ugr", ugr_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
